// File: rtl/hypipe_ingress_arb.sv
// hypipe_ingress_arb: packet-atomic 2:1 arbiter feeding the HyPipe_Top ingress bus.
// One input is the configuration-packet stream and the other is the data-packet stream.
// Packets are never interleaved on the output, and a fixed idle gap follows each packet.
// Malformed framing and over-length packets are cut off and counted as errors.
// Optional macro HYPIPE_ARB_CFG_PRIO_EN gives CFG strict priority in IDLE instead of round-robin.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no packet open; arbitrate between ports with valid flits
// XFER_CFG | forwarding a config packet, head already sent
// XFER_PKT | forwarding a data packet, head already sent
// DROP     | swallowing flits of drop_pkt's port up to and including a tail
// GAP      | forced idle cycles on o_data_valid before the next packet
module hypipe_ingress_arb #(
    parameter int GAP_CYC   = 1,
    parameter int MAX_FLITS = 64,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cfg_valid,
    input  logic [133:0]     i_cfg_data,
    output logic             o_cfg_ready,
    input  logic             i_pkt_valid,
    input  logic [133:0]     i_pkt_data,
    output logic             o_pkt_ready,
    output logic             o_data_valid,
    output logic [133:0]     o_data,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_cnt_cfg,
    output logic [CNT_W-1:0] o_cnt_pkt,
    output logic [CNT_W-1:0] o_cnt_err
);

    typedef enum logic [2:0] {IDLE, XFER_CFG, XFER_PKT, DROP, GAP} state_t;

    localparam logic [7:0]  MAX_F    = 8'(MAX_FLITS);
    localparam logic [15:0] GAP_LOAD = (GAP_CYC > 0) ? 16'(GAP_CYC - 1) : 16'd0;
    localparam state_t      END_ST   = (GAP_CYC > 0) ? GAP : IDLE;

    state_t       state;
    logic         last_grant_pkt;
    logic         drop_pkt;
    logic [7:0]   flit_cnt;
    logic [15:0]  gap_cnt;

    logic         win_pkt;
    logic         sel_pkt;
    logic         sel_valid;
    logic [133:0] sel_data;
    logic [133:0] tail_flit;
    logic         take_en;
    logic         fire;
    logic         is_head;
    logic         is_tail;
    logic [7:0]   cnt_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Port selection, readies and decode of the flit currently offered by the selected port
    always_comb begin
`ifdef HYPIPE_ARB_CFG_PRIO_EN
        win_pkt = !i_cfg_valid;
`else
        win_pkt = !i_cfg_valid || (i_pkt_valid && !last_grant_pkt);
`endif
        case (state)
            IDLE:     sel_pkt = win_pkt;
            XFER_PKT: sel_pkt = 1'b1;
            DROP:     sel_pkt = drop_pkt;
            default:  sel_pkt = 1'b0;
        endcase
        take_en   = (state == XFER_CFG) || (state == XFER_PKT) || (state == DROP) ||
                    ((state == IDLE) && (i_cfg_valid || i_pkt_valid));
        sel_valid = sel_pkt ? i_pkt_valid : i_cfg_valid;
        sel_data  = sel_pkt ? i_pkt_data : i_cfg_data;
        fire      = take_en && sel_valid;
        is_head   = (sel_data[133:132] == 2'b01);
        is_tail   = (sel_data[133:132] == 2'b10);
        tail_flit = {2'b10, sel_data[131:0]};
        cnt_next  = flit_cnt + 8'd1;
    end

    assign o_cfg_ready = take_en && !sel_pkt;
    assign o_pkt_ready = take_en && sel_pkt;
    assign o_busy      = (state != IDLE);

    // Packet FSM with registered output flit and saturating statistics
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            last_grant_pkt <= 1'b1;
            drop_pkt       <= 1'b0;
            flit_cnt       <= 8'd0;
            gap_cnt        <= 16'd0;
            o_data_valid   <= 1'b0;
            o_data         <= '0;
            o_cnt_cfg      <= '0;
            o_cnt_pkt      <= '0;
            o_cnt_err      <= '0;
        end else begin
            o_data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        last_grant_pkt <= sel_pkt;
                        if (is_head) begin
                            o_data       <= sel_data;
                            o_data_valid <= 1'b1;
                            flit_cnt     <= 8'd1;
                            state        <= sel_pkt ? XFER_PKT : XFER_CFG;
                        end else begin
                            o_cnt_err <= sat_inc(o_cnt_err);
                            if (!is_tail) begin
                                drop_pkt <= sel_pkt;
                                state    <= DROP;
                            end
                        end
                    end
                end
                XFER_CFG, XFER_PKT: begin
                    if (fire) begin
                        flit_cnt     <= cnt_next;
                        o_data_valid <= 1'b1;
                        if (is_tail) begin
                            o_data  <= sel_data;
                            if (state == XFER_PKT) o_cnt_pkt <= sat_inc(o_cnt_pkt);
                            else                   o_cnt_cfg <= sat_inc(o_cnt_cfg);
                            state   <= END_ST;
                            gap_cnt <= GAP_LOAD;
                        end else if (is_head) begin
                            // a new head closes the open packet; its own body is left to IDLE
                            o_data    <= tail_flit;
                            o_cnt_err <= sat_inc(o_cnt_err);
                            state     <= END_ST;
                            gap_cnt   <= GAP_LOAD;
                        end else if (cnt_next == MAX_F) begin
                            o_data    <= tail_flit;
                            o_cnt_err <= sat_inc(o_cnt_err);
                            drop_pkt  <= (state == XFER_PKT);
                            state     <= DROP;
                        end else begin
                            o_data <= sel_data;
                        end
                    end
                end
                DROP: begin
                    if (fire && is_tail) begin
                        state   <= END_ST;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (gap_cnt == 16'd0) state <= IDLE;
                    else                  gap_cnt <= gap_cnt - 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hypipe_ingress_arb.sv
// Testbench for hypipe_ingress_arb: directed packet scenarios checked against a packet-level model.
// The priority scenario is only compiled when HYPIPE_ARB_CFG_PRIO_EN is defined.
module tb_hypipe_ingress_arb;

    localparam int GAP_CYC   = 1;
    localparam int MAX_FLITS = 64;
    localparam int CNT_W     = 16;

    logic             i_clk;
    logic             i_rst;
    logic             i_cfg_valid;
    logic [133:0]     i_cfg_data;
    logic             o_cfg_ready;
    logic             i_pkt_valid;
    logic [133:0]     i_pkt_data;
    logic             o_pkt_ready;
    logic             o_data_valid;
    logic [133:0]     o_data;
    logic             o_busy;
    logic [CNT_W-1:0] o_cnt_cfg;
    logic [CNT_W-1:0] o_cnt_pkt;
    logic [CNT_W-1:0] o_cnt_err;

    hypipe_ingress_arb #(.GAP_CYC(GAP_CYC), .MAX_FLITS(MAX_FLITS), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cfg_valid(i_cfg_valid), .i_cfg_data(i_cfg_data), .o_cfg_ready(o_cfg_ready),
        .i_pkt_valid(i_pkt_valid), .i_pkt_data(i_pkt_data), .o_pkt_ready(o_pkt_ready),
        .o_data_valid(o_data_valid), .o_data(o_data), .o_busy(o_busy),
        .o_cnt_cfg(o_cnt_cfg), .o_cnt_pkt(o_cnt_pkt), .o_cnt_err(o_cnt_err)
    );

    int checks = 0;
    int errors = 0;

    // driver queues (what each port will present) and model queues (same flits)
    logic [133:0] dq_c[$];
    logic [133:0] dq_p[$];
    logic [133:0] mq_c[$];
    logic [133:0] mq_p[$];
    logic [133:0] exp_q[$];
    int m_last, m_cfg, m_pkt, m_err;

    // observation state kept by the compare process
    bit           cmp_en = 1'b0;
    bit           gap_exact = 1'b0;
    bit           prev_tail;
    int           idle_run;
    int           n_out;
    logic [7:0]   head_ports;
    logic [133:0] last_out;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string name, input logic [133:0] got, input logic [133:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chki(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic logic [133:0] mk(input logic [1:0] h, input int port, input int pk, input int fl);
        logic [7:0] pk8;
        logic [7:0] fl8;
        logic       pb;
        pk8 = 8'(pk);
        fl8 = 8'(fl);
        pb  = (port != 0);
        return {h, fl8[3:0], pb, 111'd0, pk8, fl8};
    endfunction

    task automatic push_flit(input int port, input logic [133:0] f, input bit to_model);
        if (port == 0) begin
            dq_c.push_back(f);
            if (to_model) mq_c.push_back(f);
        end else begin
            dq_p.push_back(f);
            if (to_model) mq_p.push_back(f);
        end
    endtask

    task automatic push_pkt(input int port, input int pk, input int nfl, input bit to_model);
        for (int i = 0; i < nfl; i++) begin
            logic [1:0] h;
            h = (i == 0) ? 2'b01 : ((i == nfl - 1) ? 2'b10 : 2'b00);
            push_flit(port, mk(h, port, pk, i), to_model);
        end
    endtask

    // ---------------- packet-level reference model ----------------
    function automatic int msize(input int p);
        return (p == 0) ? mq_c.size() : mq_p.size();
    endfunction

    function automatic logic [133:0] mpop(input int p);
        if (p == 0) return mq_c.pop_front();
        return mq_p.pop_front();
    endfunction

    task automatic mdrop(input int p);
        logic [133:0] f;
        while (msize(p) > 0) begin
            f = mpop(p);
            if (f[133:132] == 2'b10) break;
        end
    endtask

    // consumes everything queued on both ports, appending the expected output stream
    task automatic model_run();
        int p;
        int n;
        logic [133:0] f;
        while (mq_c.size() > 0 || mq_p.size() > 0) begin
            if (mq_c.size() > 0 && mq_p.size() > 0) begin
`ifdef HYPIPE_ARB_CFG_PRIO_EN
                p = 0;
`else
                p = (m_last == 1) ? 0 : 1;
`endif
            end else begin
                p = (mq_c.size() > 0) ? 0 : 1;
            end
            m_last = p;
            f = mpop(p);
            if (f[133:132] != 2'b01) begin
                m_err++;
                if (f[133:132] != 2'b10) mdrop(p);
            end else begin
                exp_q.push_back(f);
                n = 1;
                while (msize(p) > 0) begin
                    f = mpop(p);
                    n++;
                    if (f[133:132] == 2'b10) begin
                        exp_q.push_back(f);
                        if (p == 0) m_cfg++; else m_pkt++;
                        break;
                    end else if (f[133:132] == 2'b01) begin
                        exp_q.push_back({2'b10, f[131:0]});
                        m_err++;
                        break;
                    end else if (n == MAX_FLITS) begin
                        exp_q.push_back({2'b10, f[131:0]});
                        m_err++;
                        mdrop(p);
                        break;
                    end else begin
                        exp_q.push_back(f);
                    end
                end
            end
        end
    endtask

    task automatic model_clear();
        mq_c.delete();
        mq_p.delete();
        exp_q.delete();
        m_last = 1;
        m_cfg = 0;
        m_pkt = 0;
        m_err = 0;
        prev_tail = 1'b0;
        idle_run = 0;
        n_out = 0;
        head_ports = 8'd0;
        last_out = '0;
    endtask

    // ---------------- port drivers ----------------
    initial begin
        bit cfire, pfire;
        i_cfg_valid = 1'b0;
        i_cfg_data  = '0;
        i_pkt_valid = 1'b0;
        i_pkt_data  = '0;
        forever begin
            @(negedge i_clk);
            cfire = i_cfg_valid && o_cfg_ready;
            pfire = i_pkt_valid && o_pkt_ready;
            @(posedge i_clk);
            #1;
            if (cfire && dq_c.size() > 0) void'(dq_c.pop_front());
            if (pfire && dq_p.size() > 0) void'(dq_p.pop_front());
            i_cfg_valid = (dq_c.size() > 0);
            i_cfg_data  = (dq_c.size() > 0) ? dq_c[0] : '0;
            i_pkt_valid = (dq_p.size() > 0);
            i_pkt_data  = (dq_p.size() > 0) ? dq_p[0] : '0;
        end
    end

    // Compare every output flit against the model stream and police inter-packet gaps
    initial begin
        forever begin
            @(negedge i_clk);
            if (cmp_en && !i_rst) begin
                if (o_data_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_flit got=%h exp=none", o_data);
                    end else begin
                        chk("o_data", o_data, exp_q.pop_front());
                    end
                    if (prev_tail) begin
                        if (gap_exact) chki("gap_exact", idle_run, GAP_CYC);
                        else           chki("gap_min", (idle_run >= GAP_CYC) ? 1 : 0, 1);
                    end
                    if (o_data[133:132] == 2'b01) head_ports = {head_ports[6:0], o_data[127]};
                    n_out++;
                    last_out  = o_data;
                    prev_tail = (o_data[133:132] == 2'b10);
                    idle_run  = 0;
                end else begin
                    idle_run++;
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chki({tag, "_valid"}, int'(o_data_valid), 0);
        chk({tag, "_data"}, o_data, 134'd0);
        chki({tag, "_busy"}, int'(o_busy), 0);
        chki({tag, "_cnt_cfg"}, int'(o_cnt_cfg), 0);
        chki({tag, "_cnt_pkt"}, int'(o_cnt_pkt), 0);
        chki({tag, "_cnt_err"}, int'(o_cnt_err), 0);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        cmp_en = 1'b0;
        i_rst = 1'b1;
        dq_c.delete();
        dq_p.delete();
        @(negedge i_clk);
        @(negedge i_clk);
        check_reset_state("reset");
        i_rst = 1'b0;
        model_clear();
        cmp_en = 1'b1;
    endtask

    task automatic drain(input string tag);
        int  cyc;
        bit  done;
        done = 1'b0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            @(negedge i_clk);
            if (dq_c.size() == 0 && dq_p.size() == 0 && !i_cfg_valid && !i_pkt_valid && !o_busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got=busy exp=idle", tag);
        end
        repeat (3) @(negedge i_clk);
        chki({tag, "_leftover"}, exp_q.size(), 0);
        chki({tag, "_cnt_cfg"}, int'(o_cnt_cfg), m_cfg);
        chki({tag, "_cnt_pkt"}, int'(o_cnt_pkt), m_pkt);
        chki({tag, "_cnt_err"}, int'(o_cnt_err), m_err);
    endtask

    initial begin
        int lat;
        i_rst = 1'b1;
        model_clear();
        repeat (2) @(posedge i_clk);
        do_reset();

        // 1: single CFG packet, PKT idle
        @(negedge i_clk);
        push_pkt(0, 1, 3, 1'b1);
        model_run();
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            lat++;
            if (o_data_valid) break;
        end
        chki("t1_first_latency", lat, 2);
        drain("t1");
        chki("t1_nout", n_out, 3);
        chki("t1_cnt_cfg_lit", int'(o_cnt_cfg), 1);

        // 2: both ports streaming 5-flit packets, round-robin with exact gap
        do_reset();
        @(negedge i_clk);
        gap_exact = 1'b1;
        push_pkt(0, 1, 5, 1'b1);
        push_pkt(0, 2, 5, 1'b1);
        push_pkt(1, 1, 5, 1'b1);
        push_pkt(1, 2, 5, 1'b1);
        model_run();
        drain("t2");
        gap_exact = 1'b0;
        chki("t2_order", int'(head_ports[3:0]), 4'b0101);
        chki("t2_nout", n_out, 20);
        chki("t2_cnt_cfg_lit", int'(o_cnt_cfg), 2);
        chki("t2_cnt_pkt_lit", int'(o_cnt_pkt), 2);

        // 5: reset in the middle of a CFG packet
        @(negedge i_clk);
        cmp_en = 1'b0;
        push_pkt(0, 9, 5, 1'b0);
        repeat (3) @(negedge i_clk);
        chki("t5_midpkt_valid", int'(o_data_valid), 1);
        i_rst = 1'b1;
        dq_c.delete();
        dq_p.delete();
        @(negedge i_clk);
        check_reset_state("t5_after_rst");
        i_rst = 1'b0;
        model_clear();
        cmp_en = 1'b1;
        @(negedge i_clk);
        push_pkt(0, 3, 3, 1'b1);
        push_pkt(1, 3, 3, 1'b1);
        model_run();
        drain("t5");
        chki("t5_order", int'(head_ports[1:0]), 2'b01);
        chki("t5_nout", n_out, 6);

        // 3: 70-flit data packet truncated at MAX_FLITS
        do_reset();
        @(negedge i_clk);
        push_pkt(1, 4, 70, 1'b1);
        model_run();
        drain("t3");
        chki("t3_nout", n_out, 64);
        chki("t3_last_hdr", int'(last_out[133:132]), 2'b10);
        chki("t3_last_idx", int'(last_out[7:0]), 63);
        chki("t3_cnt_err_lit", int'(o_cnt_err), 1);
        chki("t3_cnt_pkt_lit", int'(o_cnt_pkt), 0);

        // 4: body then tail in IDLE on PKT, followed by a good packet
        do_reset();
        @(negedge i_clk);
        push_flit(1, mk(2'b00, 1, 5, 0), 1'b1);
        push_flit(1, mk(2'b10, 1, 5, 1), 1'b1);
        push_pkt(1, 6, 3, 1'b1);
        model_run();
        drain("t4");
        chki("t4_nout", n_out, 3);
        chki("t4_cnt_err_lit", int'(o_cnt_err), 1);
        chki("t4_cnt_pkt_lit", int'(o_cnt_pkt), 1);

        // 4b: lone tail in IDLE, then a packet cut short by a second head
        @(negedge i_clk);
        push_flit(0, mk(2'b10, 0, 7, 0), 1'b1);
        push_flit(0, mk(2'b01, 0, 8, 0), 1'b1);
        push_flit(0, mk(2'b00, 0, 8, 1), 1'b1);
        push_flit(0, mk(2'b01, 0, 8, 2), 1'b1);
        push_flit(0, mk(2'b00, 0, 8, 3), 1'b1);
        push_flit(0, mk(2'b10, 0, 8, 4), 1'b1);
        model_run();
        drain("t4b");
        chki("t4b_nout", n_out, 6);
        chki("t4b_last_hdr", int'(last_out[133:132]), 2'b10);
        chki("t4b_last_idx", int'(last_out[7:0]), 2);
        chki("t4b_cnt_err_lit", int'(o_cnt_err), 4);
        chki("t4b_cnt_cfg_lit", int'(o_cnt_cfg), 0);

`ifdef HYPIPE_ARB_CFG_PRIO_EN
        // 6: strict CFG priority, open data packet not preempted
        do_reset();
        @(negedge i_clk);
        push_pkt(1, 1, 5, 1'b1);
        model_run();
        repeat (3) @(negedge i_clk);
        push_pkt(0, 1, 4, 1'b1);
        push_pkt(0, 2, 4, 1'b1);
        push_pkt(1, 2, 4, 1'b1);
        model_run();
        drain("t6");
        chki("t6_order", int'(head_ports[3:0]), 4'b1001);
        chki("t6_cnt_cfg_lit", int'(o_cnt_cfg), 2);
        chki("t6_cnt_pkt_lit", int'(o_cnt_pkt), 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
